// File: rtl/pp_tile_scheduler.sv
// Ping-pong bank scheduler for a tiled matmul job: steers loader beats into the
// free bank and hands each full bank to the systolic array in alternating order.
module pp_tile_scheduler #(
    parameter int NUM_TILES  = 16,
    parameter int FILL_BEATS = 8,
    parameter int ADDR_WIDTH = $clog2(FILL_BEATS),
    parameter int CNT_WIDTH  = $clog2(NUM_TILES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  job_done,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  drain_start,
    output logic                  drain_bank,
    input  logic                  drain_done,
    output logic [1:0]            bank_full,
    output logic [CNT_WIDTH-1:0]  tiles_drained
);

    typedef enum logic {S_IDLE, S_RUN} top_state_e;
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_e;

    top_state_e            state_q;
    bank_state_e           bank_q [2];
    logic                  fp_q;
    logic                  dp_q;
    logic [ADDR_WIDTH-1:0] beat_cnt_q;
    logic [CNT_WIDTH-1:0]  tiles_filled_q;
    logic [CNT_WIDTH-1:0]  tiles_drained_q;
    logic                  drain_start_q;
    logic                  drain_bank_q;
    logic                  job_done_q;

    logic run;
    logic fill_free;
    logic accept;
    logic last_beat;
    logic any_draining;
    logic kick;
    logic done_acc;
    logic job_init;

    assign run          = (state_q == S_RUN);
    assign fill_free    = (bank_q[fp_q] == B_EMPTY) || (bank_q[fp_q] == B_FILLING);
    assign in_ready     = run && fill_free && (tiles_filled_q < CNT_WIDTH'(NUM_TILES)) && !abort;
    assign accept       = in_valid && in_ready;
    assign last_beat    = accept && (beat_cnt_q == ADDR_WIDTH'(FILL_BEATS - 1));
    assign any_draining = (bank_q[0] == B_DRAINING) || (bank_q[1] == B_DRAINING);
    assign kick         = run && !any_draining && (bank_q[dp_q] == B_FULL);
    // drain_done arriving together with drain_start belongs to no handed-over bank
    assign done_acc     = run && drain_done && !drain_start_q && (bank_q[dp_q] == B_DRAINING);
    assign job_init     = abort || (!run && start);

    assign busy          = run;
    assign job_done      = job_done_q;
    assign wr_en         = accept;
    assign wr_bank       = fp_q;
    assign wr_addr       = beat_cnt_q;
    assign drain_start   = drain_start_q;
    assign drain_bank    = drain_bank_q;
    assign tiles_drained = tiles_drained_q;
    assign bank_full[0]  = (bank_q[0] == B_FULL) || (bank_q[0] == B_DRAINING);
    assign bank_full[1]  = (bank_q[1] == B_FULL) || (bank_q[1] == B_DRAINING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            bank_q[0]       <= B_EMPTY;
            bank_q[1]       <= B_EMPTY;
            fp_q            <= 1'b0;
            dp_q            <= 1'b0;
            beat_cnt_q      <= '0;
            tiles_filled_q  <= '0;
            tiles_drained_q <= '0;
            drain_start_q   <= 1'b0;
            drain_bank_q    <= 1'b0;
            job_done_q      <= 1'b0;
        end else begin
            drain_start_q <= 1'b0;
            job_done_q    <= 1'b0;
            if (job_init) begin
                // abort wins over a coincident start and also lands here from IDLE
                state_q         <= abort ? S_IDLE : S_RUN;
                bank_q[0]       <= B_EMPTY;
                bank_q[1]       <= B_EMPTY;
                fp_q            <= 1'b0;
                dp_q            <= 1'b0;
                beat_cnt_q      <= '0;
                tiles_filled_q  <= '0;
                tiles_drained_q <= '0;
            end else if (run) begin
                if (last_beat) begin
                    beat_cnt_q     <= '0;
                    bank_q[fp_q]   <= B_FULL;
                    fp_q           <= ~fp_q;
                    tiles_filled_q <= tiles_filled_q + 1'b1;
                end else if (accept) begin
                    beat_cnt_q   <= beat_cnt_q + 1'b1;
                    bank_q[fp_q] <= B_FILLING;
                end
                if (kick) begin
                    drain_start_q <= 1'b1;
                    drain_bank_q  <= dp_q;
                    bank_q[dp_q]  <= B_DRAINING;
                end
                if (done_acc) begin
                    bank_q[dp_q]    <= B_EMPTY;
                    dp_q            <= ~dp_q;
                    tiles_drained_q <= tiles_drained_q + 1'b1;
                    if (tiles_drained_q == CNT_WIDTH'(NUM_TILES - 1)) begin
                        state_q    <= S_IDLE;
                        job_done_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/pp_tile_scheduler.md
Name: pp_tile_scheduler

Overview:
- Sequences one ping-pong bank pair for a tiled matmul job.
- Accepts a stream of load beats, steers them into the free bank and generates write addresses.
- Hands each full bank to the systolic array, then recycles the bank when the array reports it has finished with it.
- Sits between the input loader and the bank write ports on one side, and the systolic array start/finish handshake and bank read mux on the other.

Parameters:
NUM_TILES, 16, tiles per job (>=1)
FILL_BEATS, 8, write beats per tile/bank (>=2)
ADDR_WIDTH, $clog2(FILL_BEATS), bank write address width
CNT_WIDTH, $clog2(NUM_TILES+1), tile counter width

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse; begin a job (ignored while busy)
abort  in  1  synchronous; kill current job
busy  out  1  job in progress
job_done  out  1  one-cycle pulse when last tile drained
in_valid  in  1  loader beat valid
in_ready  out  1  scheduler can accept beat
wr_en  out  1  bank write strobe
wr_bank  out  1  bank being written
wr_addr  out  ADDR_WIDTH  write address within bank
drain_start  out  1  one-cycle pulse; array may consume drain_bank
drain_bank  out  1  bank owned by array / read-mux select
drain_done  in  1  array finished with drain_bank
bank_full  out  2  per-bank FULL-or-DRAINING status
tiles_drained  out  CNT_WIDTH  tiles completed in current job

Behaviour:
- Reset values (async rst): all outputs 0; top FSM IDLE; both banks EMPTY; fill pointer fp=0; drain pointer dp=0; beat/tile counters 0.
- Top FSM: IDLE -> RUN on start. RUN -> IDLE when the tiles_drained increment reaches NUM_TILES; job_done pulses in that cycle after the edge, i.e. the cycle in which busy first reads 0. RUN -> IDLE on abort: banks cleared, counters cleared, no job_done. busy = (state==RUN).
- Per-bank state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
- Fill side:
  - in_ready = RUN & (bank[fp] EMPTY or FILLING) & tiles_filled<NUM_TILES & !abort.
  - Beat accepted when in_valid & in_ready. wr_en = accept (combinational, same cycle); wr_bank = fp; wr_addr = beat_cnt.
  - First accepted beat moves bank[fp] to FILLING.
  - On the beat with beat_cnt==FILL_BEATS-1: beat_cnt wraps to 0, bank[fp] -> FULL, fp toggles, tiles_filled++.
  - in_ready is 0 while bank[fp] is FULL/DRAINING (backpressure). There is never an overwrite of an unconsumed bank.
- Drain side:
  - When RUN, no drain outstanding and bank[dp]==FULL: drain_start is registered high for exactly one cycle, drain_bank<=dp, and bank[dp] -> DRAINING on the same edge.
  - Latency: last fill beat at cycle T, FULL visible at T+1, drain_start at T+2.
  - drain_done is ignored in the drain_start cycle and whenever no bank is DRAINING.
  - An accepted drain_done sets bank[dp] -> EMPTY, toggles dp and increments tiles_drained (registered).
  - drain_bank holds its value after completion until the next drain_start.
- Ordering: fills and drains both alternate 0,1,0,1...; tile order is preserved.
- Simultaneous events:
  - A last fill beat on one bank and drain_done on the other in the same cycle both take effect.
  - A last fill beat into bank X and drain_done freeing bank X cannot coincide, because fill is blocked on a non-EMPTY/FILLING bank.
  - start and abort together: abort wins and the FSM stays IDLE.
  - start in RUN: ignored.
- tiles_drained clears on start and abort. It holds its final value in IDLE after job_done.
- bank_full[b] = bank b is FULL or DRAINING.
- Reset mid-job returns everything to reset values immediately. wr_en drops combinationally because in_ready=0.

Test Plan:
- NUM_TILES=4, FILL_BEATS=8, in_valid held 1, array returns drain_done 20 cycles after each drain_start:
  - wr_addr runs 0..7 per tile; wr_bank sequence 0,1,0,1.
  - Drain_start count = 4 with drain_bank 0,1,0,1.
  - job_done pulses once; tiles_drained=4.
- Slow array (drain_done 100 cycles after start):
  - After both banks are filled, in_ready=0 and bank_full=2'b11 until the first drain_done.
  - Filling then resumes on bank 0 at wr_addr 0.
- Last fill beat of bank 1 in the same cycle as drain_done for bank 0:
  - Next cycle bank_full=2'b10, fp=0, tiles_drained increments by 1.
  - drain_start for bank 1 follows one cycle later.
- Spurious drain_done pulses in IDLE and in a drain_start cycle: no state change, tiles_drained unchanged.
- abort asserted mid-tile (wr_addr=3, tile 2):
  - Next cycle busy=0, in_ready=0, bank_full=0, tiles_drained=0, no job_done.
  - A new start restarts at bank 0, wr_addr 0.
- Async rst asserted between clock edges during DRAINING: all outputs 0 immediately, without waiting for a clock edge.
